// File: rtl/fifo_pkg.sv
// Shared helpers for the parametrised dual-clock FIFO.
//   - fifo_depth:      DEPTH derived from ADDR_WIDTH
//   - addr_width_ok / sync_stages_ok: legal-range predicates for elaboration checks
//   - bin2gray / gray2bin: pointer encodings. Both operate on a zero-extended
//     MaxPtrWidth vector, so callers of any narrower width cast in and out.
package fifo_pkg;

   localparam int unsigned MinAddrWidth   = 2;
   localparam int unsigned MaxAddrWidth   = 12;
   localparam int unsigned MinSyncStages  = 2;
   localparam int unsigned MaxSyncStages  = 4;
   localparam int unsigned MaxPtrWidth    = MaxAddrWidth + 1;

   typedef logic [MaxPtrWidth-1:0] ptr_max_t;

   function automatic int unsigned fifo_depth(input int unsigned addr_width);
      return 32'd1 << addr_width;
   endfunction

   function automatic logic addr_width_ok(input int unsigned addr_width);
      return (addr_width >= MinAddrWidth) && (addr_width <= MaxAddrWidth);
   endfunction

   function automatic logic sync_stages_ok(input int unsigned sync_stages);
      return (sync_stages >= MinSyncStages) && (sync_stages <= MaxSyncStages);
   endfunction

   // Zero upper bits stay zero in both directions, so the result is valid for
   // any width up to MaxPtrWidth after truncation.
   function automatic ptr_max_t bin2gray(input ptr_max_t bin);
      return bin ^ (bin >> 1);
   endfunction

   function automatic ptr_max_t gray2bin(input ptr_max_t gray);
      ptr_max_t bin;
      bin[MaxPtrWidth-1] = gray[MaxPtrWidth-1];
      for (int i = MaxPtrWidth - 2; i >= 0; i--) begin
         bin[i] = bin[i+1] ^ gray[i];
      end
      return bin;
   endfunction

endpackage

// File: rtl/gray_ptr_sync.sv
// Gray-coded pointer crossing into a destination clock domain.
// Ports:
//   dst_clk   - destination clock
//   dst_reset - asynchronous, active-high destination reset
//   gray_in   - Gray pointer registered in the source domain
//   bin_out   - synchronised pointer converted back to binary (combinational
//               from the last synchroniser stage)
module gray_ptr_sync #(
   parameter int unsigned WIDTH       = 5,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             dst_clk,
   input  logic             dst_reset,
   input  logic [WIDTH-1:0] gray_in,
   output logic [WIDTH-1:0] bin_out
);
   import fifo_pkg::*;

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] sync_d [SYNC_STAGES];

   always_comb begin
      sync_d[0] = gray_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end
   end

   always_ff @(posedge dst_clk or posedge dst_reset) begin
      if (dst_reset) begin
         sync_q <= '{default: '0};
      end else begin
         sync_q <= sync_d;
      end
   end

   assign bin_out = WIDTH'(gray2bin(ptr_max_t'(sync_q[SYNC_STAGES-1])));

endmodule

// File: rtl/async_fifo_param.sv
// Parametrised dual-clock FIFO with inferred two-port memory.
// Write domain (wr_clk, wr_reset): wr_en, wr_data, full, almost_full,
//   wr_count, overflow (one-cycle pulse on a write while full).
// Read domain (rd_clk, rd_reset): rd_en, rd_data, rd_valid, empty,
//   almost_empty, rd_count, underflow (one-cycle pulse on a read while empty).
// FWFT=0: rd_data is loaded one edge after an accepted rd_en, with rd_valid.
// FWFT=1: a one-entry output register holds the head word; empty = !valid.
// All flags are registered and conservative; only Gray pointers cross domains.
module async_fifo_param #(
   parameter int unsigned DATA_WIDTH       = 16,
   parameter int unsigned ADDR_WIDTH       = 4,
   parameter int unsigned ALMOST_FULL_GAP  = 3,
   parameter int unsigned ALMOST_EMPTY_GAP = 3,
   parameter int unsigned FWFT             = 0,
   parameter int unsigned SYNC_STAGES      = 2
) (
   input  logic                  wr_clk,
   input  logic                  wr_reset,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  full,
   output logic                  almost_full,
   output logic [ADDR_WIDTH:0]   wr_count,
   output logic                  overflow,
   input  logic                  rd_clk,
   input  logic                  rd_reset,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  empty,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   rd_count,
   output logic                  underflow
);
   import fifo_pkg::*;

   localparam int unsigned Depth      = fifo_depth(ADDR_WIDTH);
   localparam int unsigned PtrW       = ADDR_WIDTH + 1;
   localparam int unsigned AfLevelInt = (ALMOST_FULL_GAP >= Depth) ? 0 : Depth - ALMOST_FULL_GAP;
   localparam int unsigned AeLevelInt = (ALMOST_EMPTY_GAP >= Depth) ? Depth : ALMOST_EMPTY_GAP;
   localparam logic [PtrW-1:0] DepthLevel = PtrW'(Depth);
   localparam logic [PtrW-1:0] AfLevel    = PtrW'(AfLevelInt);
   localparam logic [PtrW-1:0] AeLevel    = PtrW'(AeLevelInt);

   if (!addr_width_ok(ADDR_WIDTH)) begin : g_bad_addr_width
      $error("async_fifo_param: ADDR_WIDTH must be in 2..12");
   end
   if (!sync_stages_ok(SYNC_STAGES)) begin : g_bad_sync_stages
      $error("async_fifo_param: SYNC_STAGES must be in 2..4");
   end

   logic [DATA_WIDTH-1:0] mem_q [Depth];

   // ---------------- write domain ----------------
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, wr_gray_q, wr_gray_d, rd_ptr_sync;
   logic [PtrW-1:0] wr_count_q, wr_count_d;
   logic            full_q, full_d, almost_full_q, almost_full_d, overflow_q, overflow_d;
   logic            wen;

   always_comb begin
      wen           = wr_en & ~full_q;
      wr_ptr_d      = wr_ptr_q + PtrW'(wen);
      // Gray copy taken from the next binary value: one bit flips per update.
      wr_gray_d     = PtrW'(bin2gray(ptr_max_t'(wr_ptr_d)));
      wr_count_d    = wr_ptr_d - rd_ptr_sync;
      full_d        = (wr_count_d == DepthLevel);
      almost_full_d = (wr_count_d >= AfLevel);
      overflow_d    = wr_en & full_q;
   end

   always_ff @(posedge wr_clk or posedge wr_reset) begin
      if (wr_reset) begin
         wr_ptr_q      <= '0;
         wr_gray_q     <= '0;
         wr_count_q    <= '0;
         full_q        <= 1'b0;
         almost_full_q <= 1'b0;
         overflow_q    <= 1'b0;
      end else begin
         wr_ptr_q      <= wr_ptr_d;
         wr_gray_q     <= wr_gray_d;
         wr_count_q    <= wr_count_d;
         full_q        <= full_d;
         almost_full_q <= almost_full_d;
         overflow_q    <= overflow_d;
      end
   end

   // Array contents are intentionally not reset.
   always_ff @(posedge wr_clk) begin
      if (wen) begin
         mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= wr_data;
      end
   end

   // ---------------- read domain ----------------
   logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d, rd_gray_q, rd_gray_d, wr_ptr_sync;
   logic [PtrW-1:0]       mem_count_q, mem_count_d, rd_count_q, rd_count_d;
   logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
   logic                  out_valid_q, out_valid_d;
   logic                  rd_valid_q, rd_valid_d, empty_q, empty_d;
   logic                  almost_empty_q, almost_empty_d, underflow_q, underflow_d;
   logic                  mem_ren;

   always_comb begin
      mem_ren     = 1'b0;
      out_valid_d = out_valid_q;
      rd_data_d   = rd_data_q;
      rd_valid_d  = 1'b0;
      underflow_d = rd_en & empty_q;
      if (FWFT != 0) begin
         // Prefetch into the output register when it is free or being popped.
         mem_ren = (mem_count_q != '0) && (!out_valid_q || rd_en);
         if (mem_ren) begin
            out_valid_d = 1'b1;
            rd_data_d   = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
         end else if (rd_en) begin
            out_valid_d = 1'b0;
         end
         rd_valid_d = out_valid_d;
      end else begin
         mem_ren = rd_en & ~empty_q;
         if (mem_ren) begin
            rd_data_d = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
         end
         rd_valid_d = mem_ren;
      end
      rd_ptr_d       = rd_ptr_q + PtrW'(mem_ren);
      rd_gray_d      = PtrW'(bin2gray(ptr_max_t'(rd_ptr_d)));
      mem_count_d    = wr_ptr_sync - rd_ptr_d;
      // Output register counts as a stored word (always 0 when FWFT=0).
      rd_count_d     = mem_count_d + PtrW'(out_valid_d);
      empty_d        = (FWFT != 0) ? !out_valid_d : (mem_count_d == '0);
      almost_empty_d = (rd_count_d <= AeLevel);
   end

   always_ff @(posedge rd_clk or posedge rd_reset) begin
      if (rd_reset) begin
         rd_ptr_q       <= '0;
         rd_gray_q      <= '0;
         mem_count_q    <= '0;
         rd_count_q     <= '0;
         rd_data_q      <= '0;
         out_valid_q    <= 1'b0;
         rd_valid_q     <= 1'b0;
         empty_q        <= 1'b1;
         almost_empty_q <= 1'b1;
         underflow_q    <= 1'b0;
      end else begin
         rd_ptr_q       <= rd_ptr_d;
         rd_gray_q      <= rd_gray_d;
         mem_count_q    <= mem_count_d;
         rd_count_q     <= rd_count_d;
         rd_data_q      <= rd_data_d;
         out_valid_q    <= out_valid_d;
         rd_valid_q     <= rd_valid_d;
         empty_q        <= empty_d;
         almost_empty_q <= almost_empty_d;
         underflow_q    <= underflow_d;
      end
   end

   // ---------------- crossings ----------------
   gray_ptr_sync #(
      .WIDTH       (PtrW),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_wr2rd_sync (
      .dst_clk   (rd_clk),
      .dst_reset (rd_reset),
      .gray_in   (wr_gray_q),
      .bin_out   (wr_ptr_sync)
   );

   gray_ptr_sync #(
      .WIDTH       (PtrW),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_rd2wr_sync (
      .dst_clk   (wr_clk),
      .dst_reset (wr_reset),
      .gray_in   (rd_gray_q),
      .bin_out   (rd_ptr_sync)
   );

   assign full         = full_q;
   assign almost_full  = almost_full_q;
   assign wr_count     = wr_count_q;
   assign overflow     = overflow_q;
   assign rd_data      = rd_data_q;
   assign rd_valid     = rd_valid_q;
   assign empty        = empty_q;
   assign almost_empty = almost_empty_q;
   assign rd_count     = rd_count_q;
   assign underflow    = underflow_q;

endmodule

// File: tb/tb_async_fifo_param.sv
// Directed bench for async_fifo_param: dut0 uses FWFT=0, dut1 uses FWFT=1.
// Time unit is treated as 100 ps: wr_clk half period 50 (100 MHz), rd_clk half
// period 50 (100 MHz, offset by 20) or 135 (about 37 MHz).
module tb_async_fifo_param;

   localparam int unsigned NumWords = 10000;

   logic        wr_clk = 1'b0;
   logic        rd_clk = 1'b0;
   int          rd_half = 50;
   logic        wr_reset, rd_reset;

   logic        wr_en0, rd_en0, wr_en1, rd_en1;
   logic [15:0] wr_data0, wr_data1, rd_data0, rd_data1;
   logic        full0, almost_full0, overflow0, rd_valid0, empty0, almost_empty0, underflow0;
   logic        full1, almost_full1, overflow1, rd_valid1, empty1, almost_empty1, underflow1;
   logic [4:0]  wr_count0, rd_count0, wr_count1, rd_count1;

   int          checks = 0;
   int          errors = 0;
   logic        gray_en = 1'b0;
   logic [4:0]  wr_gray_prev = '0;
   logic [4:0]  rd_gray_prev = '0;
   logic [15:0] sb_q [$];

   always #50 wr_clk = ~wr_clk;
   initial begin
      #20;
      forever #(rd_half) rd_clk = ~rd_clk;
   end

   async_fifo_param #(.FWFT(0)) dut0 (
      .wr_clk       (wr_clk),
      .wr_reset     (wr_reset),
      .wr_en        (wr_en0),
      .wr_data      (wr_data0),
      .full         (full0),
      .almost_full  (almost_full0),
      .wr_count     (wr_count0),
      .overflow     (overflow0),
      .rd_clk       (rd_clk),
      .rd_reset     (rd_reset),
      .rd_en        (rd_en0),
      .rd_data      (rd_data0),
      .rd_valid     (rd_valid0),
      .empty        (empty0),
      .almost_empty (almost_empty0),
      .rd_count     (rd_count0),
      .underflow    (underflow0)
   );

   async_fifo_param #(.FWFT(1)) dut1 (
      .wr_clk       (wr_clk),
      .wr_reset     (wr_reset),
      .wr_en        (wr_en1),
      .wr_data      (wr_data1),
      .full         (full1),
      .almost_full  (almost_full1),
      .wr_count     (wr_count1),
      .overflow     (overflow1),
      .rd_clk       (rd_clk),
      .rd_reset     (rd_reset),
      .rd_en        (rd_en1),
      .rd_data      (rd_data1),
      .rd_valid     (rd_valid1),
      .empty        (empty1),
      .almost_empty (almost_empty1),
      .rd_count     (rd_count1),
      .underflow    (underflow1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Gray pointers must change by at most one bit per clock during traffic.
   always @(negedge wr_clk) begin
      if (gray_en) begin
         checks++;
         assert ($countones(dut0.wr_gray_q ^ wr_gray_prev) <= 1) else begin
            errors++;
            $error("FAIL wr_gray_step: observed %0h expected one-bit step from %0h",
                   dut0.wr_gray_q, wr_gray_prev);
         end
      end
      wr_gray_prev = dut0.wr_gray_q;
   end

   always @(negedge rd_clk) begin
      if (gray_en) begin
         checks++;
         assert ($countones(dut0.rd_gray_q ^ rd_gray_prev) <= 1) else begin
            errors++;
            $error("FAIL rd_gray_step: observed %0h expected one-bit step from %0h",
                   dut0.rd_gray_q, rd_gray_prev);
         end
      end
      rd_gray_prev = dut0.rd_gray_q;
   end

   initial begin
      int   wr_sent, rd_issued, rd_done, wr_cyc, rd_cyc;
      logic saw_ovf, saw_unf;
      logic [31:0] exp_w;

      // ---- 1: reset ----
      wr_reset = 1'b1; rd_reset = 1'b1;
      wr_en0 = 0; rd_en0 = 0; wr_en1 = 0; rd_en1 = 0;
      wr_data0 = '0; wr_data1 = '0;
      repeat (4) @(negedge wr_clk);
      wr_reset = 1'b0;
      @(negedge rd_clk);
      rd_reset = 1'b0;
      @(negedge wr_clk);
      chk("rst_full", full0, 0);
      chk("rst_almost_full", almost_full0, 0);
      chk("rst_wr_count", wr_count0, 0);
      chk("rst_overflow", overflow0, 0);
      chk("rst_empty", empty0, 1);
      chk("rst_almost_empty", almost_empty0, 1);
      chk("rst_rd_count", rd_count0, 0);
      chk("rst_underflow", underflow0, 0);
      chk("rst_rd_valid", rd_valid0, 0);
      chk("rst_rd_data", rd_data0, 0);
      chk("rst_fwft_empty", empty1, 1);
      chk("rst_fwft_rd_valid", rd_valid1, 0);

      // ---- 2: fill 16 words ----
      wr_en0 = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         wr_data0 = 16'(i);
         @(negedge wr_clk);
         if (i == 12) chk("fill12_almost_full", almost_full0, 0);
         if (i == 13) begin
            chk("fill13_almost_full", almost_full0, 1);
            chk("fill13_wr_count", wr_count0, 13);
         end
         if (i == 15) chk("fill15_full", full0, 0);
         if (i == 16) begin
            chk("fill16_full", full0, 1);
            chk("fill16_wr_count", wr_count0, 16);
            chk("fill16_overflow", overflow0, 0);
         end
      end
      wr_data0 = 16'h0011;
      @(negedge wr_clk);
      chk("ovf_pulse", overflow0, 1);
      chk("ovf_wr_count", wr_count0, 16);
      wr_en0 = 1'b0;
      @(negedge wr_clk);
      chk("ovf_clear", overflow0, 0);

      // ---- 3: drain with FWFT=0 ----
      repeat (4) @(negedge rd_clk);
      chk("drain_rd_count", rd_count0, 16);
      chk("drain_almost_empty", almost_empty0, 0);
      rd_en0 = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         @(negedge rd_clk);
         chk("drain_data", rd_data0, i);
         chk("drain_valid", rd_valid0, 1);
         if (i == 12) chk("drain12_almost_empty", almost_empty0, 0);
         if (i == 13) chk("drain13_almost_empty", almost_empty0, 1);
         if (i == 15) chk("drain15_empty", empty0, 0);
         if (i == 16) chk("drain16_empty", empty0, 1);
      end
      @(negedge rd_clk);
      chk("unf_pulse", underflow0, 1);
      chk("unf_rd_data", rd_data0, 16'h0010);
      chk("unf_rd_valid", rd_valid0, 0);
      rd_en0 = 1'b0;
      @(negedge rd_clk);
      chk("unf_clear", underflow0, 0);
      repeat (5) @(negedge wr_clk);
      chk("drain_wr_count", wr_count0, 0);
      chk("drain_full", full0, 0);

      // ---- 4: FWFT single word ----
      @(negedge wr_clk);
      wr_en1 = 1'b1; wr_data1 = 16'hA5A5;
      @(posedge wr_clk);
      #1 wr_en1 = 1'b0;
      repeat (3) @(negedge rd_clk);
      chk("fwft_edge3_empty", empty1, 1);
      @(negedge rd_clk);
      chk("fwft_edge4_empty", empty1, 0);
      chk("fwft_data", rd_data1, 16'hA5A5);
      chk("fwft_rd_valid", rd_valid1, 1);
      chk("fwft_rd_count", rd_count1, 1);
      rd_en1 = 1'b1;
      @(negedge rd_clk);
      rd_en1 = 1'b0;
      chk("fwft_pop_empty", empty1, 1);
      chk("fwft_pop_rd_valid", rd_valid1, 0);
      chk("fwft_pop_underflow", underflow1, 0);

      // ---- 5: random traffic, rd_clk ~37 MHz ----
      rd_half = 135;
      repeat (4) @(negedge rd_clk);
      gray_en = 1'b1;
      saw_ovf = 0; saw_unf = 0;
      wr_sent = 0; rd_issued = 0; rd_done = 0; wr_cyc = 0; rd_cyc = 0;
      fork
         begin
            while (wr_sent < NumWords && wr_cyc < 80000) begin
               @(negedge wr_clk);
               wr_cyc++;
               if (overflow0) saw_ovf = 1;
               wr_en0 = !full0 && ($urandom % 2 == 0);
               if (wr_en0) begin
                  wr_data0 = 16'(wr_sent);
                  sb_q.push_back(16'(wr_sent));
                  wr_sent++;
               end
            end
            @(negedge wr_clk);
            wr_en0 = 1'b0;
         end
         begin
            while (rd_done < NumWords && rd_cyc < 30000) begin
               @(negedge rd_clk);
               rd_cyc++;
               if (underflow0) saw_unf = 1;
               if (rd_valid0) begin
                  exp_w = (sb_q.size() != 0) ? 32'(sb_q.pop_front()) : 32'hFFFF_FFFF;
                  chk("t5_order", rd_data0, exp_w);
                  rd_done++;
               end
               rd_en0 = !empty0 && (rd_issued < NumWords) && ($urandom % 4 != 0);
               if (rd_en0) rd_issued++;
            end
            rd_en0 = 1'b0;
         end
      join
      gray_en = 1'b0;
      chk("t5_words_read", rd_done, NumWords);
      chk("t5_sb_left", sb_q.size(), 0);
      chk("t5_no_overflow", saw_ovf, 0);
      chk("t5_no_underflow", saw_unf, 0);

      // ---- 6: reset with words stored ----
      rd_half = 50;
      repeat (3) @(negedge rd_clk);
      @(negedge wr_clk);
      wr_en0 = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         wr_data0 = 16'(16'h5000 + i);
         @(negedge wr_clk);
      end
      wr_data0 = 16'h5006;
      repeat (6) @(negedge rd_clk);
      wr_en0 = 1'b0;
      chk("pre_rst_empty", empty0, 0);
      wr_reset = 1'b1; rd_reset = 1'b1;
      repeat (4) @(negedge wr_clk);
      chk("mid_rst_full", full0, 0);
      chk("mid_rst_almost_full", almost_full0, 0);
      chk("mid_rst_wr_count", wr_count0, 0);
      chk("mid_rst_overflow", overflow0, 0);
      chk("mid_rst_empty", empty0, 1);
      chk("mid_rst_almost_empty", almost_empty0, 1);
      chk("mid_rst_rd_count", rd_count0, 0);
      chk("mid_rst_underflow", underflow0, 0);
      chk("mid_rst_rd_valid", rd_valid0, 0);
      wr_reset = 1'b0;
      @(negedge rd_clk);
      rd_reset = 1'b0;
      @(negedge wr_clk);
      wr_en0 = 1'b1; wr_data0 = 16'h6001;
      @(negedge wr_clk);
      wr_data0 = 16'h6002;
      @(negedge wr_clk);
      wr_en0 = 1'b0;
      repeat (6) @(negedge rd_clk);
      chk("post_rst_rd_count", rd_count0, 2);
      rd_en0 = 1'b1;
      @(negedge rd_clk);
      rd_en0 = 1'b0;
      chk("post_rst_first_data", rd_data0, 16'h6001);
      chk("post_rst_rd_valid", rd_valid0, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
